proc_ctrl_fsm: RTL and testbench
================================

Name: proc_ctrl_fsm

Overview:
Control sequencer for the 9-bit bus processor; it is the initiator for the bus driver-select mux.
- Captures an instruction word from DIN into an internal IR.
- Steps through timesteps T0..T3.
- Generates the one-hot bus driver selects (R0..R7, DIN, G), the register/A/G load enables, the ALU add/sub control and done.
- At most one bus driver select is ever high. The mux therefore never receives a multi-hot select.

Parameters:
WIDTH, 9, instruction/din width. WIDTH >= 9. Decode uses opcode = ir[8:6], X = ir[5:3], Y = ir[2:0]. Bits above 8 are ignored.

Ports:
clk  in  1  system clock; all state updates on rising edge
resetn  in  1  asynchronous active-low reset
run  in  1  start request; sampled only in T0
din  in  WIDTH  instruction word; captured into IR on the T0->T1 edge
r_out  out  8  bus driver selects; bit i = Ri drives bus
din_out  out  1  DIN drives bus
g_out  out  1  G drives bus
r_in  out  8  register load enables; bit i loads Ri from bus
a_in  out  1  load A from bus
g_in  out  1  load G with ALU result
add_sub  out  1  ALU op: 0 = A+bus, 1 = A-bus
done  out  1  high in the final timestep of an instruction
ir  out  WIDTH  current IR contents (debug/visibility)

Behaviour:
- State: 2-bit timestep register tstep in {T0,T1,T2,T3}, plus the IR register.
- Reset: resetn low forces tstep=T0 and IR=0 immediately, without waiting for clk. An instruction in flight is abandoned; no completion cycle.
- All control outputs are combinational from (tstep, IR). With tstep=T0, every control output and done is 0.
- ir output equals IR; reset value 0.
- T0 (idle/fetch): if run=1 at the clock edge, then IR<=din and tstep->T1. Otherwise stay in T0 and hold IR. run is ignored in T1..T3.
- Opcode 000, mv Rx,Ry. T1: r_out[Y]=1, r_in[X]=1, done=1; next T0.
- Opcode 001, mvi Rx,#D. T1: din_out=1, r_in[X]=1, done=1; next T0. The immediate must be on din during T1.
- Opcode 010, add Rx,Ry:
  - T1: r_out[X]=1, a_in=1; next T2.
  - T2: r_out[Y]=1, g_in=1, add_sub=0; next T3.
  - T3: g_out=1, r_in[X]=1, done=1; next T0.
- Opcode 011, sub Rx,Ry: same as add except add_sub=1 in T2. add_sub is 0 in every other timestep.
- Opcodes 100..111 (undefined): T1 has all selects/enables 0 and done=1; next T0 (NOP, 2 cycles total).
- Latency from the run-sampling edge: mv/mvi/NOP finish in 1 cycle (done in T1); add/sub finish in 3 cycles (done in T3).
- Back-to-back: with run held high, every instruction is followed by exactly one T0 cycle before the next T1. The next din is captured on the edge that leaves T0.
- X == Y is legal and decodes normally. Example: mv R3,R3 asserts r_out[3] and r_in[3] together.
- Invariant in every cycle: popcount({r_out, din_out, g_out}) <= 1.
- Invariant: r_in is zero or one-hot.
- Invariant: a_in and g_in are never asserted together with any r_in bit.
- tstep never reaches T2 or T3 for mv, mvi or undefined opcodes. An unreachable encoding recovers to T0 on the next edge.

Test Plan:
- Reset: resetn=0 while in add T2 -> tstep=T0, ir=0, all outputs 0 in that same cycle. After release with run=0, outputs stay 0 for 5 cycles.
- mv R2,R5 (din=9'b000_010_101, run=1 for one cycle):
  - T1: r_out=8'h20, r_in=8'h04, done=1.
  - Next cycle: all outputs 0.
- mvi R3 (din=9'b001_011_000, then din=9'h01A in T1): T1 has din_out=1, r_in=8'h08, done=1. ir=9'h058.
- add R1,R4 (din=9'b010_001_100):
  - T1: r_out=8'h02, a_in=1.
  - T2: r_out=8'h10, g_in=1, add_sub=0.
  - T3: g_out=1, r_in=8'h02, done=1.
- sub R7,R0 (9'b011_111_000) with run held high, followed by mv R0,R7 (9'b000_000_111):
  - sub: T2 has add_sub=1; T3 has r_in=8'h80 and done=1.
  - Then one T0 cycle with outputs 0.
  - Then mv T1: r_out=8'h80, r_in=8'h01.
- Undefined opcode 9'b111_000_000: T1 has done=1 and every select/enable 0. Over a 200-instruction random run, a checker confirms the popcount/one-hot invariants and that done comes exactly 1 or 3 cycles after each run-sampling edge.

Source files
------------

// File: rtl/proc_ctrl_fsm.sv
`default_nettype none
// proc_ctrl_fsm: timestep sequencer for the 9-bit bus processor.
// Fetches an instruction into IR and drives one-hot bus selects and load enables.
module proc_ctrl_fsm #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic [WIDTH-1:0] din,
  output logic [7:0]       r_out,
  output logic             din_out,
  output logic             g_out,
  output logic [7:0]       r_in,
  output logic             a_in,
  output logic             g_in,
  output logic             add_sub,
  output logic             done,
  output logic [WIDTH-1:0] ir
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  localparam logic [2:0] c_OP_MV  = 3'b000;
  localparam logic [2:0] c_OP_MVI = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_SUB = 3'b011;

  tstep_t           r_tstep;
  logic [WIDTH-1:0] r_ir;

  logic [2:0] w_op;
  logic [2:0] w_x;
  logic [2:0] w_y;
  logic [7:0] w_xsel;
  logic [7:0] w_ysel;
  logic       w_arith;

  assign w_op    = r_ir[8:6];
  assign w_x     = r_ir[5:3];
  assign w_y     = r_ir[2:0];
  assign w_xsel  = 8'b1 << w_x;
  assign w_ysel  = 8'b1 << w_y;
  assign w_arith = (w_op == c_OP_ADD) || (w_op == c_OP_SUB);
  assign ir      = r_ir;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tstep <= T0;
      r_ir    <= '0;
    end else begin
      case (r_tstep)
        T0: begin
          if (run) begin
            r_ir    <= din;
            r_tstep <= T1;
          end
        end
        T1:      r_tstep <= w_arith ? T2 : T0;
        // T2/T3 with a non-arithmetic opcode cannot occur; fall back to T0.
        T2:      r_tstep <= w_arith ? T3 : T0;
        T3:      r_tstep <= T0;
        default: r_tstep <= T0;
      endcase
    end
  end

  always_comb begin
    r_out   = '0;
    din_out = 1'b0;
    g_out   = 1'b0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    add_sub = 1'b0;
    done    = 1'b0;
    case (r_tstep)
      T1: begin
        case (w_op)
          c_OP_MV: begin
            r_out = w_ysel;
            r_in  = w_xsel;
            done  = 1'b1;
          end
          c_OP_MVI: begin
            din_out = 1'b1;
            r_in    = w_xsel;
            done    = 1'b1;
          end
          c_OP_ADD, c_OP_SUB: begin
            r_out = w_xsel;
            a_in  = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        if (w_arith) begin
          r_out   = w_ysel;
          g_in    = 1'b1;
          add_sub = w_op[0];
        end
      end
      T3: begin
        if (w_arith) begin
          g_out = 1'b1;
          r_in  = w_xsel;
          done  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_ctrl_fsm.sv
`default_nettype none
// tb_proc_ctrl_fsm: directed and randomised checks of the processor control sequencer.
module tb_proc_ctrl_fsm;

  logic       clk;
  logic       resetn;
  logic       run;
  logic [8:0] din;
  logic [7:0] r_out;
  logic       din_out;
  logic       g_out;
  logic [7:0] r_in;
  logic       a_in;
  logic       g_in;
  logic       add_sub;
  logic       done;
  logic [8:0] ir;

  int checks = 0;
  int errors = 0;

  proc_ctrl_fsm #(.WIDTH(9)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .run     (run),
    .din     (din),
    .r_out   (r_out),
    .din_out (din_out),
    .g_out   (g_out),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .add_sub (add_sub),
    .done    (done),
    .ir      (ir)
  );

  // {r_out, din_out, g_out, r_in, a_in, g_in, add_sub, done}
  logic [21:0] obs;
  assign obs = {r_out, din_out, g_out, r_in, a_in, g_in, add_sub, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] pk(input logic [7:0] ro, input logic di, input logic go,
                                     input logic [7:0] ri, input logic ai, input logic gi,
                                     input logic as, input logic dn);
    return {ro, di, go, ri, ai, gi, as, dn};
  endfunction

  // Expected outputs for a given opcode/X/Y in timestep 1..3.
  function automatic logic [21:0] model(input logic [8:0] instr, input int step);
    logic [2:0] op;
    logic [7:0] xs;
    logic [7:0] ys;
    op = instr[8:6];
    xs = 8'h00; xs[instr[5:3]] = 1'b1;
    ys = 8'h00; ys[instr[2:0]] = 1'b1;
    if (step == 1) begin
      if (op == 3'd0) return pk(ys, 0, 0, xs, 0, 0, 0, 1);
      if (op == 3'd1) return pk(8'h00, 1, 0, xs, 0, 0, 0, 1);
      if (op == 3'd2 || op == 3'd3) return pk(xs, 0, 0, 8'h00, 1, 0, 0, 0);
      return pk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
    end
    if (step == 2) return pk(ys, 0, 0, 8'h00, 0, 1, op[0], 0);
    if (step == 3) return pk(8'h00, 0, 1, xs, 0, 0, 0, 1);
    return 22'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; run = 1'b0; din = 9'h000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 22'h0 || ir !== 9'h000) begin
      errors++; $display("FAIL reset_init: outs=%h ir=%h required outs=0 ir=0", obs, ir);
    end
    resetn = 1'b1;
    din = 9'b010_001_100; run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    checks++;
    if (obs !== pk(8'h10, 0, 0, 8'h00, 0, 1, 0, 0)) begin
      errors++; $display("FAIL reset_pre_t2: outs=%h required %h", obs, pk(8'h10, 0, 0, 8'h00, 0, 1, 0, 0));
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (obs !== 22'h0 || ir !== 9'h000) begin
      errors++; $display("FAIL reset_async: outs=%h ir=%h required outs=0 ir=0", obs, ir);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs !== 22'h0 || ir !== 9'h000) begin
        errors++; $display("FAIL reset_idle[%0d]: outs=%h ir=%h required outs=0 ir=0", i, obs, ir);
      end
    end
  endtask

  task automatic test_mv();
    din = 9'b000_010_101; run = 1'b1;
    tick();
    run = 1'b0;
    checks++;
    if (obs !== pk(8'h20, 0, 0, 8'h04, 0, 0, 0, 1)) begin
      errors++; $display("FAIL mv_t1: outs=%h required %h", obs, pk(8'h20, 0, 0, 8'h04, 0, 0, 0, 1));
    end
    tick();
    checks++;
    if (obs !== 22'h0) begin
      errors++; $display("FAIL mv_after: outs=%h required 0", obs);
    end
    din = 9'b000_011_011; run = 1'b1;
    tick();
    run = 1'b0;
    checks++;
    if (obs !== pk(8'h08, 0, 0, 8'h08, 0, 0, 0, 1)) begin
      errors++; $display("FAIL mv_same_reg: outs=%h required %h", obs, pk(8'h08, 0, 0, 8'h08, 0, 0, 0, 1));
    end
    tick();
  endtask

  task automatic test_mvi();
    din = 9'b001_011_000; run = 1'b1;
    tick();
    din = 9'h01A; run = 1'b0;
    checks++;
    if (obs !== pk(8'h00, 1, 0, 8'h08, 0, 0, 0, 1)) begin
      errors++; $display("FAIL mvi_t1: outs=%h required %h", obs, pk(8'h00, 1, 0, 8'h08, 0, 0, 0, 1));
    end
    checks++;
    if (ir !== 9'h058) begin
      errors++; $display("FAIL mvi_ir: ir=%h required 058", ir);
    end
    tick();
    checks++;
    if (obs !== 22'h0 || ir !== 9'h058) begin
      errors++; $display("FAIL mvi_after: outs=%h ir=%h required outs=0 ir=058", obs, ir);
    end
  endtask

  task automatic test_add();
    din = 9'b010_001_100; run = 1'b1;
    tick();
    run = 1'b0;
    checks++;
    if (obs !== pk(8'h02, 0, 0, 8'h00, 1, 0, 0, 0)) begin
      errors++; $display("FAIL add_t1: outs=%h required %h", obs, pk(8'h02, 0, 0, 8'h00, 1, 0, 0, 0));
    end
    tick();
    checks++;
    if (obs !== pk(8'h10, 0, 0, 8'h00, 0, 1, 0, 0)) begin
      errors++; $display("FAIL add_t2: outs=%h required %h", obs, pk(8'h10, 0, 0, 8'h00, 0, 1, 0, 0));
    end
    tick();
    checks++;
    if (obs !== pk(8'h00, 0, 1, 8'h02, 0, 0, 0, 1)) begin
      errors++; $display("FAIL add_t3: outs=%h required %h", obs, pk(8'h00, 0, 1, 8'h02, 0, 0, 0, 1));
    end
    tick();
    checks++;
    if (obs !== 22'h0) begin
      errors++; $display("FAIL add_after: outs=%h required 0", obs);
    end
  endtask

  task automatic test_back_to_back();
    din = 9'b011_111_000; run = 1'b1;
    tick();
    din = 9'b000_000_111;
    checks++;
    if (obs !== pk(8'h80, 0, 0, 8'h00, 1, 0, 0, 0)) begin
      errors++; $display("FAIL b2b_sub_t1: outs=%h required %h", obs, pk(8'h80, 0, 0, 8'h00, 1, 0, 0, 0));
    end
    tick();
    checks++;
    if (obs !== pk(8'h01, 0, 0, 8'h00, 0, 1, 1, 0)) begin
      errors++; $display("FAIL b2b_sub_t2: outs=%h required %h", obs, pk(8'h01, 0, 0, 8'h00, 0, 1, 1, 0));
    end
    tick();
    checks++;
    if (obs !== pk(8'h00, 0, 1, 8'h80, 0, 0, 0, 1) || ir !== 9'b011_111_000) begin
      errors++; $display("FAIL b2b_sub_t3: outs=%h ir=%h required %h ir=0f8", obs, ir, pk(8'h00, 0, 1, 8'h80, 0, 0, 0, 1));
    end
    tick();
    checks++;
    if (obs !== 22'h0) begin
      errors++; $display("FAIL b2b_gap: outs=%h required 0", obs);
    end
    tick();
    run = 1'b0;
    checks++;
    if (obs !== pk(8'h80, 0, 0, 8'h01, 0, 0, 0, 1)) begin
      errors++; $display("FAIL b2b_mv_t1: outs=%h required %h", obs, pk(8'h80, 0, 0, 8'h01, 0, 0, 0, 1));
    end
    tick();
  endtask

  task automatic test_undef();
    din = 9'b111_000_000; run = 1'b1;
    tick();
    run = 1'b0;
    checks++;
    if (obs !== pk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1)) begin
      errors++; $display("FAIL undef_t1: outs=%h required %h", obs, pk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1));
    end
    tick();
    checks++;
    if (obs !== 22'h0) begin
      errors++; $display("FAIL undef_after: outs=%h required 0", obs);
    end
  endtask

  task automatic test_random();
    logic [8:0] instr;
    int         lat;
    instr = 9'($urandom_range(0, 511));
    din = instr; run = 1'b1;
    for (int n = 0; n < 200; n++) begin
      tick();
      lat = (instr[8:6] == 3'd2 || instr[8:6] == 3'd3) ? 3 : 1;
      for (int c = 1; c <= lat; c++) begin
        din = 9'($urandom_range(0, 511));
        checks++;
        if ($countones({r_out, din_out, g_out}) > 1 || !$onehot0(r_in) || ((a_in || g_in) && (r_in != 8'h00))) begin
          errors++; $display("FAIL rand_invariant[%0d.%0d]: outs=%h", n, c, obs);
        end
        checks++;
        if (obs !== model(instr, c) || done !== (c == lat) || ir !== instr) begin
          errors++; $display("FAIL rand_step[%0d.%0d]: outs=%h ir=%h required outs=%h ir=%h", n, c, obs, ir, model(instr, c), instr);
        end
        tick();
      end
      instr = 9'($urandom_range(0, 511));
      din = instr;
      checks++;
      if (obs !== 22'h0) begin
        errors++; $display("FAIL rand_gap[%0d]: outs=%h required 0", n, obs);
      end
    end
    run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_mv();
    test_mvi();
    test_add();
    test_back_to_back();
    test_undef();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
